decode_pipe: RTL
================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter INST_WIDTH, default 16: instruction width; legal values are 16 and above.
REQ-002 Parameter DEPTH, default 2: number of entries in the output buffer; must be a power of 2, minimum 2.
REQ-003 Derived width IMM_WIDTH = INST_WIDTH-8.
REQ-004 clk  in  1  single clock; all state updates on the posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 flush  in  1  discards all buffered decodes.
REQ-007 in_valid  in  1  inst is valid this cycle.
REQ-008 in_ready  out  1  block accepts inst this cycle.
REQ-009 inst  in  INST_WIDTH  raw instruction.
REQ-010 out_valid  out  1  head entry is valid.
REQ-011 out_ready  in  1  consumer takes the head entry.
REQ-012 immediate  out  IMM_WIDTH  copy of inst[INST_WIDTH-1:8].
REQ-013 inst_type  out  2  copy of inst[1:0].
REQ-014 rf_write_addr  out  3  register-file write address.
REQ-015 rX_addr  out  3  rX read address.
REQ-016 reg_used  out  1  address fields are meaningful.
REQ-017 illegal  out  1  instruction is undefined.

Function
REQ-018 Decode SHALL be combinational on inst: type 01/10 -> both addresses = inst[7:5], reg_used=1.
REQ-019 Type 11 with inst[7:2]=100000 (0TOX) -> rf_write_addr=inst[10:8], rX_addr=0, reg_used=1.
REQ-020 Type 11 with inst[7:2]=100001 (XTO0) -> rf_write_addr=0, rX_addr=inst[10:8], reg_used=1.
REQ-021 Type 11 with any other inst[7:2] -> illegal=1, reg_used=0, both addresses 0.
REQ-022 Type 00 -> reg_used=0, illegal=0, both addresses 0; no output SHALL ever be X.
REQ-023 Push on in_valid&&in_ready; the decoded entry SHALL be written into a DEPTH-entry circular buffer.
REQ-024 Latency: an entry accepted in cycle N SHALL appear with out_valid=1 in cycle N+1 at the earliest; there is no combinational in->out path.
REQ-025 in_ready = (count<DEPTH), a registered-state function only, independent of out_ready.
REQ-026 out_valid = (count!=0); a pop SHALL occur on out_valid&&out_ready; outputs SHALL be held stable while out_valid&&!out_ready.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; both pointers advance.
REQ-028 Read/write pointers SHALL wrap from DEPTH-1 to 0; count width is clog2(DEPTH)+1.
REQ-029 flush SHALL zero count and both pointers at the next edge and dominates any push or pop in that cycle; the input of that cycle is dropped.
REQ-030 When out_valid=0 the data outputs SHALL read 0.

Reset
REQ-031 rst SHALL immediately clear count and pointers, giving out_valid=0, in_ready=1 and all data outputs 0.
REQ-032 rst asserted mid-transfer SHALL discard all entries; the first push after deassertion is the first entry seen at the output.

Structure
REQ-033 Package decode_pkg SHALL hold: inst_type enum (2 bits), OP_0TOX=6'b100000, OP_XTO0=6'b100001, REG_ADDR_WIDTH=3, packed struct decoded_t.
REQ-034 One sub-module, decode_fifo, parametrised on DEPTH and payload width, SHALL hold the buffer, pointers and count; decode_pipe holds the decode logic.

Verification
REQ-035 Push 16'h0583 with out_ready=1 -> next cycle: out_valid=1, rf_write_addr=5, rX_addr=0, immediate=8'h05, reg_used=1.
REQ-036 Push 16'h0687 -> rX_addr=6, rf_write_addr=0, inst_type=3; push 16'h12E1 -> both addresses=7, immediate=8'h12, inst_type=1.
REQ-037 Push 16'h00FF -> illegal=1, reg_used=0, both addresses=0.
REQ-038 out_ready=0 with DEPTH=2: after 2 pushes in_ready=0 and a third push is ignored; then out_ready=1 -> entries pop in order, one per cycle.
REQ-039 Buffer holding 1 entry, flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry retained.
REQ-040 rst pulse while 2 entries are held -> out_valid=0 at once; a push of 16'h0583 afterwards is output first.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and constants for the instruction decode pipeline.
package decode_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 3;
  localparam logic [5:0] OP_0TOX = 6'b100000;
  localparam logic [5:0] OP_XTO0 = 6'b100001;

  typedef enum logic [1:0] {
    TypeNone = 2'b00,
    TypeRegA = 2'b01,
    TypeRegB = 2'b10,
    TypeExt  = 2'b11
  } inst_type_e;

  // Immediate is carried alongside the struct since its width follows INST_WIDTH.
  typedef struct packed {
    inst_type_e                inst_type;
    logic [REG_ADDR_WIDTH-1:0] rf_write_addr;
    logic [REG_ADDR_WIDTH-1:0] rx_addr;
    logic                      reg_used;
    logic                      illegal;
  } decoded_t;

endpackage

// File: rtl/decode_fifo.sv
// Circular buffer of decoded entries with valid/ready handshakes on both sides.
module decode_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push, pop;

  assign in_ready  = (count_q < DepthCnt);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  // Storage is never reset, so the head is masked whenever it is not valid.
  assign rdata     = out_valid ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/decode_pipe.sv
// Combinational instruction decode feeding a registered output buffer.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int unsigned INST_WIDTH = 16,
  parameter int unsigned DEPTH      = 2,
  localparam int unsigned IMM_WIDTH = INST_WIDTH - 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INST_WIDTH-1:0]     inst,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IMM_WIDTH-1:0]      immediate,
  output logic [1:0]                inst_type,
  output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
  output logic [REG_ADDR_WIDTH-1:0] rX_addr,
  output logic                      reg_used,
  output logic                      illegal
);

  localparam int unsigned PayloadWidth = IMM_WIDTH + $bits(decoded_t);

  decoded_t                dec, head;
  logic [IMM_WIDTH-1:0]    head_imm;
  logic [PayloadWidth-1:0] wdata, rdata;

  always_comb begin
    dec               = '0;
    dec.inst_type     = inst_type_e'(inst[1:0]);
    unique case (inst_type_e'(inst[1:0]))
      TypeRegA, TypeRegB: begin
        dec.rf_write_addr = inst[7:5];
        dec.rx_addr       = inst[7:5];
        dec.reg_used      = 1'b1;
      end
      TypeExt: begin
        if (inst[7:2] == OP_0TOX) begin
          dec.rf_write_addr = inst[10:8];
          dec.reg_used      = 1'b1;
        end else if (inst[7:2] == OP_XTO0) begin
          dec.rx_addr  = inst[10:8];
          dec.reg_used = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign wdata = {inst[INST_WIDTH-1:8], dec};

  decode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PayloadWidth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wdata     (wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rdata     (rdata)
  );

  assign {head_imm, head} = rdata;
  assign immediate        = head_imm;
  assign inst_type        = head.inst_type;
  assign rf_write_addr    = head.rf_write_addr;
  assign rX_addr          = head.rx_addr;
  assign reg_used         = head.reg_used;
  assign illegal          = head.illegal;

endmodule
